// File: rtl/vme_bus_arbiter.sv
// Two-requester arbiter in front of a single VME-style memory port.
// Requesters A and B share one downstream channel with a single
// transaction outstanding at a time. Simultaneous requests alternate
// round-robin. A transaction with no downstream completion is aborted
// after TIMEOUT wait cycles and reported to the requester as an error.
module vme_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // requester A
  input  logic              a_req_rd,
  input  logic              a_req_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wr_data,
  output logic [31:0]       a_rd_data,
  output logic              a_done,
  output logic              a_err,
  // requester B
  input  logic              b_req_rd,
  input  logic              b_req_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wr_data,
  output logic [31:0]       b_rd_data,
  output logic              b_done,
  output logic              b_err,
  // downstream bus
  output logic [ADDR_W-1:0] vme_addr,
  output logic [31:0]       vme_wr_data,
  output logic              vme_rd_mem,
  output logic              vme_wr_mem,
  input  logic [31:0]       vme_rd_data,
  input  logic              vme_rd_done,
  input  logic              vme_wr_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                grant_b_q;   // current transaction owner: 1 = B
  logic                last_b_q;    // round-robin pointer: 1 = B was granted last
  logic                is_wr_q;     // current transaction direction
  logic                err_q;       // current transaction timed out
  logic [7:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         a_rd_q, b_rd_q;

  logic a_req, b_req, pick_b, match_done, timeout_hit;

  assign a_req       = a_req_rd | a_req_wr;
  assign b_req       = b_req_rd | b_req_wr;
  // B wins when alone, or on a tie when A was the last one granted.
  assign pick_b      = b_req & (~a_req | ~last_b_q);
  // Only a completion of the type matching the issued strobe counts.
  assign match_done  = is_wr_q ? vme_wr_done : vme_rd_done;
  assign timeout_hit = (cnt_q == TIMEOUT_CNT);

  // Next-state logic for the transaction sequencer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (a_req || b_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (match_done || timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register plus the grant, request capture, wait counter and
  // read-data registers, all advanced by the current state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;           // favour A on the first tie
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rd_q    <= '0;
      b_rd_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (a_req || b_req) begin
            grant_b_q <= pick_b;
            last_b_q  <= pick_b;
            // A simultaneous read and write request is serviced as a write.
            is_wr_q   <= pick_b ? b_req_wr  : a_req_wr;
            addr_q    <= pick_b ? b_addr    : a_addr;
            wdata_q   <= pick_b ? b_wr_data : a_wr_data;
            cnt_q     <= '0;
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (match_done) begin
            err_q <= 1'b0;
            if (!is_wr_q) begin
              if (grant_b_q) b_rd_q <= vme_rd_data;
              else           a_rd_q <= vme_rd_data;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (!is_wr_q) begin
              if (grant_b_q) b_rd_q <= 32'hFFFF_FFFF;
              else           a_rd_q <= 32'hFFFF_FFFF;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and completion pulses decode directly from registered state.
  assign vme_rd_mem  = (state_q == ST_ISSUE) & ~is_wr_q;
  assign vme_wr_mem  = (state_q == ST_ISSUE) &  is_wr_q;
  assign vme_addr    = addr_q;
  assign vme_wr_data = wdata_q;

  assign a_done    = (state_q == ST_DONE) & ~grant_b_q;
  assign b_done    = (state_q == ST_DONE) &  grant_b_q;
  assign a_err     = a_done & err_q;
  assign b_err     = b_done & err_q;
  assign a_rd_data = a_rd_q;
  assign b_rd_data = b_rd_q;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Directed testbench for vme_bus_arbiter (ADDR_W=8, TIMEOUT=15).
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// the same point, so each tick() lands in the next clock cycle.
module tb_vme_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req_rd, a_req_wr, b_req_rd, b_req_wr;
  logic [7:0]  a_addr, b_addr, vme_addr;
  logic [31:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
  logic        a_done, a_err, b_done, b_err;
  logic [31:0] vme_wr_data, vme_rd_data;
  logic        vme_rd_mem, vme_wr_mem, vme_rd_done, vme_wr_done;

  int n_assert = 0;
  int n_fail   = 0;

  vme_bus_arbiter #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .a_req_rd(a_req_rd), .a_req_wr(a_req_wr), .a_addr(a_addr),
    .a_wr_data(a_wr_data), .a_rd_data(a_rd_data), .a_done(a_done), .a_err(a_err),
    .b_req_rd(b_req_rd), .b_req_wr(b_req_wr), .b_addr(b_addr),
    .b_wr_data(b_wr_data), .b_rd_data(b_rd_data), .b_done(b_done), .b_err(b_err),
    .vme_addr(vme_addr), .vme_wr_data(vme_wr_data),
    .vme_rd_mem(vme_rd_mem), .vme_wr_mem(vme_wr_mem),
    .vme_rd_data(vme_rd_data), .vme_rd_done(vme_rd_done), .vme_wr_done(vme_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One round of the contention test; both requests stay high throughout.
  task automatic tie_round(input bit exp_b, input string tag);
    tick(); // ISSUE
    check({tag, " wr strobe"}, {31'd0, vme_wr_mem}, 32'd1);
    check({tag, " rd strobe"}, {31'd0, vme_rd_mem}, 32'd0);
    check({tag, " addr"}, {24'd0, vme_addr}, exp_b ? 32'hB2 : 32'hA1);
    check({tag, " wdata"}, vme_wr_data, exp_b ? 32'hBBBB_0002 : 32'hAAAA_0001);
    tick(); // WAIT
    check({tag, " no strobe in wait"}, {31'd0, vme_wr_mem | vme_rd_mem}, 32'd0);
    vme_wr_done = 1'b1;
    tick(); // DONE
    vme_wr_done = 1'b0;
    check({tag, " a_done"}, {31'd0, a_done}, {31'd0, ~exp_b});
    check({tag, " b_done"}, {31'd0, b_done}, {31'd0, exp_b});
    check({tag, " no strobe in done"}, {31'd0, vme_wr_mem | vme_rd_mem}, 32'd0);
    tick(); // IDLE
    check({tag, " no strobe in idle"}, {31'd0, vme_wr_mem | vme_rd_mem}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_req_rd = 0; a_req_wr = 0; a_addr = 8'h00; a_wr_data = 32'h0;
    b_req_rd = 0; b_req_wr = 0; b_addr = 8'h00; b_wr_data = 32'h0;
    vme_rd_data = 32'h0; vme_rd_done = 0; vme_wr_done = 0;

    // ---- reset values
    tick();
    tick();
    check("rst rd strobe", {31'd0, vme_rd_mem}, 32'd0);
    check("rst wr strobe", {31'd0, vme_wr_mem}, 32'd0);
    check("rst dones", {30'd0, a_done, b_done}, 32'd0);
    check("rst errs", {30'd0, a_err, b_err}, 32'd0);
    check("rst vme_addr", {24'd0, vme_addr}, 32'd0);
    check("rst vme_wr_data", vme_wr_data, 32'd0);
    check("rst a_rd_data", a_rd_data, 32'd0);
    check("rst b_rd_data", b_rd_data, 32'd0);
    rst = 1'b0;

    // ---- A write 0x1234 @ 0x04, done one cycle after strobe
    a_req_wr = 1; a_addr = 8'h04; a_wr_data = 32'h1234;       // cycle N (IDLE)
    tick();                                                    // N+1
    check("aw strobe", {31'd0, vme_wr_mem}, 32'd1);
    check("aw rd strobe", {31'd0, vme_rd_mem}, 32'd0);
    check("aw addr", {24'd0, vme_addr}, 32'h04);
    check("aw data", vme_wr_data, 32'h1234);
    tick();                                                    // N+2
    check("aw strobe one cycle", {31'd0, vme_wr_mem}, 32'd0);
    check("aw done early", {31'd0, a_done}, 32'd0);
    vme_wr_done = 1;
    tick();                                                    // N+3
    vme_wr_done = 0;
    check("aw a_done", {31'd0, a_done}, 32'd1);
    check("aw a_err", {31'd0, a_err}, 32'd0);
    check("aw b_done", {31'd0, b_done}, 32'd0);
    tick();                                                    // N+4
    a_req_wr = 0;
    check("aw done one cycle", {31'd0, a_done}, 32'd0);
    check("aw addr held", {24'd0, vme_addr}, 32'h04);

    // ---- B read, data returned two cycles after strobe
    b_req_rd = 1; b_addr = 8'h10;
    tick();
    check("br rd strobe", {31'd0, vme_rd_mem}, 32'd1);
    check("br wr strobe", {31'd0, vme_wr_mem}, 32'd0);
    check("br addr", {24'd0, vme_addr}, 32'h10);
    tick();
    tick();
    vme_rd_done = 1; vme_rd_data = 32'hCAFE_0001;
    tick();
    vme_rd_done = 0; vme_rd_data = 32'h0;
    check("br b_done", {31'd0, b_done}, 32'd1);
    check("br errs", {30'd0, a_err, b_err}, 32'd0);
    check("br b_rd_data", b_rd_data, 32'hCAFE_0001);
    check("br a_done", {31'd0, a_done}, 32'd0);
    check("br a_rd_data untouched", a_rd_data, 32'd0);
    tick();
    b_req_rd = 0;
    check("br done one cycle", {31'd0, b_done}, 32'd0);
    check("br rd_data held", b_rd_data, 32'hCAFE_0001);

    // ---- A read+write together is a write; wrong-type done is ignored
    a_req_rd = 1; a_req_wr = 1; a_addr = 8'h20; a_wr_data = 32'h55;
    tick();
    check("rw wr strobe", {31'd0, vme_wr_mem}, 32'd1);
    check("rw rd strobe", {31'd0, vme_rd_mem}, 32'd0);
    tick();
    vme_rd_done = 1; vme_rd_data = 32'hDEAD_DEAD;
    tick();
    vme_rd_done = 0;
    check("rw rd_done ignored", {31'd0, a_done}, 32'd0);
    vme_wr_done = 1;
    tick();
    vme_wr_done = 0;
    check("rw a_done", {31'd0, a_done}, 32'd1);
    check("rw a_rd_data untouched", a_rd_data, 32'd0);
    tick();
    a_req_rd = 0; a_req_wr = 0;

    // ---- contention after reset: A, B, A, B
    rst = 1;
    tick();
    rst = 0;
    a_req_wr = 1; a_addr = 8'hA1; a_wr_data = 32'hAAAA_0001;
    b_req_wr = 1; b_addr = 8'hB2; b_wr_data = 32'hBBBB_0002;
    tie_round(1'b0, "tie1");
    tie_round(1'b1, "tie2");
    tie_round(1'b0, "tie3");
    tie_round(1'b1, "tie4");
    a_req_wr = 0; b_req_wr = 0;
    tick();
    check("tie idle after drop", {31'd0, vme_wr_mem | vme_rd_mem}, 32'd0);

    // ---- A read timeout; a late read done is ignored
    a_req_rd = 1; a_addr = 8'h33;
    tick();
    check("to rd strobe", {31'd0, vme_rd_mem}, 32'd1);
    tick();                                                    // WAIT entry, count 0
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (a_done !== 1'b0) check("to premature done", {31'd0, a_done}, 32'd0);
    end
    check("to still waiting", {31'd0, a_done}, 32'd0);
    tick();                                                    // 16 cycles after entry
    check("to a_done", {31'd0, a_done}, 32'd1);
    check("to a_err", {31'd0, a_err}, 32'd1);
    check("to a_rd_data", a_rd_data, 32'hFFFF_FFFF);
    check("to b_done", {31'd0, b_done}, 32'd0);
    vme_rd_done = 1; vme_rd_data = 32'h1234_5678;
    tick();
    a_req_rd = 0;
    check("to done one cycle", {31'd0, a_done}, 32'd0);
    check("to err cleared", {31'd0, a_err}, 32'd0);
    tick();
    vme_rd_done = 0;
    check("to late done ignored", a_rd_data, 32'hFFFF_FFFF);
    check("to no new strobe", {31'd0, vme_wr_mem | vme_rd_mem}, 32'd0);

    // ---- B read whose done lands on the final wait cycle: success
    b_req_rd = 1; b_addr = 8'h3C;
    tick();                                                    // ISSUE
    tick();                                                    // WAIT entry
    for (int i = 1; i <= 14; i++) tick();
    tick();                                                    // count == 15
    vme_rd_done = 1; vme_rd_data = 32'h0000_BEEF;
    tick();
    vme_rd_done = 0;
    check("edge b_done", {31'd0, b_done}, 32'd1);
    check("edge b_err", {31'd0, b_err}, 32'd0);
    check("edge b_rd_data", b_rd_data, 32'h0000_BEEF);
    tick();
    b_req_rd = 0;

    // ---- reset during WAIT of a B write aborts it
    b_req_wr = 1; b_addr = 8'h44; b_wr_data = 32'h99;
    tick();
    check("rb wr strobe", {31'd0, vme_wr_mem}, 32'd1);
    tick();                                                    // WAIT
    rst = 1;
    tick();
    check("rb no b_done", {31'd0, b_done}, 32'd0);
    check("rb vme_addr", {24'd0, vme_addr}, 32'd0);
    check("rb vme_wr_data", vme_wr_data, 32'd0);
    check("rb b_rd_data", b_rd_data, 32'd0);
    check("rb a_rd_data", a_rd_data, 32'd0);
    rst = 0; b_req_wr = 0; vme_wr_done = 1;
    tick();
    vme_wr_done = 0;
    check("rb late done ignored", {30'd0, a_done, b_done}, 32'd0);
    a_req_rd = 1; a_addr = 8'h55;
    tick();
    check("rb next rd strobe", {31'd0, vme_rd_mem}, 32'd1);
    check("rb next addr", {24'd0, vme_addr}, 32'h55);
    tick();
    vme_rd_done = 1; vme_rd_data = 32'h600D_F00D;
    tick();
    vme_rd_done = 0;
    check("rb next a_done", {31'd0, a_done}, 32'd1);
    check("rb next a_err", {31'd0, a_err}, 32'd0);
    check("rb next a_rd_data", a_rd_data, 32'h600D_F00D);
    tick();
    a_req_rd = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vme_bus_arbiter.md
VME_BUS_ARBITER -- requirements
Module: vme_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, address width of both requester ports and the downstream bus.
REQ-002 Parameter: TIMEOUT, default 15, maximum cycles to wait for a downstream done before aborting; legal range 1..255.
REQ-003 Clk  in  1  sole clock; all logic rising-edge.
REQ-004 Rst  in  1  synchronous, active-high reset.
REQ-005 AReqRd, AReqWr  in  1 each  requester A read/write request, level, held until ADone.
REQ-006 AAddr  in  ADDR_W  requester A address; AWrData  in  32  requester A write data.
REQ-007 ARdData  out  32  read data to A; ADone  out  1  one-cycle completion pulse; AErr  out  1  timeout flag, valid with ADone.
REQ-008 BReqRd, BReqWr, BAddr, BWrData, BRdData, BDone, BErr  mirror REQ-005..REQ-007 for requester B.
REQ-009 VMEAddr  out  ADDR_W  downstream address; VMEWrData  out  32  downstream write data.
REQ-010 VMERdMem, VMEWrMem  out  1 each  downstream one-cycle read/write strobes.
REQ-011 VMERdData  in  32  downstream read data, valid with VMERdDone.
REQ-012 VMERdDone, VMEWrDone  in  1 each  downstream completion pulses.

Function
REQ-013 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transaction outstanding downstream at any time.
REQ-014 IDLE: if either requester has ReqRd or ReqWr high, grant and go to ISSUE next cycle; else stay IDLE.
REQ-015 Both requesting in the same IDLE cycle: grant the requester not granted last (round-robin); after reset, A wins the first tie.
REQ-016 Single requester: granted regardless of round-robin pointer; pointer updates to the granted requester on every grant.
REQ-017 On grant, register address, write data and direction; ReqWr and ReqRd both high from the granted requester is treated as a write.
REQ-018 ISSUE: drive VMERdMem or VMEWrMem high for exactly one cycle with VMEAddr/VMEWrData stable; go to WAIT.
REQ-019 VMEAddr and VMEWrData hold the registered values from ISSUE until the next ISSUE.
REQ-020 WAIT: a 8-bit counter starts at 0 on entry and increments each WAIT cycle.
REQ-021 WAIT, read in progress: on VMERdDone, latch VMERdData into the granted RdData, clear Err, go to DONE.
REQ-022 WAIT, write in progress: on VMEWrDone, clear Err and go to DONE.
REQ-023 Done of the non-matching type in WAIT is ignored; done pulses in IDLE, ISSUE or DONE are ignored.
REQ-024 WAIT: when counter reaches TIMEOUT with no matching done, set Err=1, RdData=0xFFFFFFFF (reads), go to DONE.
REQ-025 Done arriving in the same cycle the counter reaches TIMEOUT counts as success (done wins).
REQ-026 DONE: pulse the granted requester's Done for one cycle, assert Err with it if the transaction timed out, return to IDLE.
REQ-027 The non-granted requester's Done/Err remain 0; its RdData holds its last value.
REQ-028 Requesters drop their request in the cycle following Done; a request still high in IDLE starts a new transaction.
REQ-029 Latency: request seen in IDLE at cycle N -> strobe at N+1; downstream done at cycle M -> requester Done at M+1.

Reset
REQ-030 While Rst is high: state IDLE, pointer favours A, counter 0, VMERdMem=VMEWrMem=0, ADone=BDone=0, AErr=BErr=0.
REQ-031 Reset values: VMEAddr=0, VMEWrData=0, ARdData=BRdData=0.
REQ-032 Rst asserted mid-transaction aborts it without Done; a downstream done arriving after reset is ignored.

Verification
REQ-033 A write 0x1234 at addr 0x04, downstream WrDone 1 cycle after strobe -> VMEWrMem one cycle at N+1 with addr 0x04/data 0x1234, ADone at N+3, AErr=0.
REQ-034 B read, downstream returns 0xCAFE0001 with RdDone 2 cycles after strobe -> BRdData=0xCAFE0001, BDone one cycle, AErr=BErr=0.
REQ-035 A and B request together repeatedly after reset -> grant order A, B, A, B; never two strobes without an intervening done/timeout.
REQ-036 A read with no downstream done, TIMEOUT=15 -> ADone with AErr=1 and ARdData=0xFFFFFFFF 16 cycles after WAIT entry; late RdDone ignored.
REQ-037 Rst asserted in WAIT of a B write -> no BDone, outputs at reset values, next A request serviced normally.
REQ-038 Requester asserts ReqRd and ReqWr together -> VMEWrMem strobe only, VMERdMem stays 0.
